// File: rtl/avalon_loopback_agent.sv
// Avalon-MM loopback responder: DATA writes fill a FIFO and DATA reads drain it; STATUS/CTRL/ID alongside.
// Optional macro AGENT_OVERFLOW_DROP_EN: full-FIFO writes are dropped and counted instead of stalling.
module avalon_loopback_agent #(
    parameter int unsigned DEPTH    = 16,
    parameter logic [31:0] ID_VALUE = 32'h5649_4430
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic [31:0]             address,
    input  logic [3:0]              byteenable,
    input  logic                    write,
    input  logic                    read,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest,
    output logic [$clog2(DEPTH):0]  level
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_ID     = 2'd3;

    // Handshake: a request is accepted on a sys_clk edge where (read|write)=1 and waitrequest=0;
    // an accepted read (read=1, write=0) yields readdatavalid=1 for exactly the following cycle.

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic          full;
    logic          empty;
    logic [1:0]    sel;
    logic          sel_data;
    logic          stall;
    logic          accept_wr;
    logic          accept_rd;
    logic          push;
    logic          pop;
    logic          clear;
    logic [31:0]   wr_word;
    logic [31:0]   rd_mux;
    logic [15:0]   level_ext;
    logic          unused_addr;

    assign sel         = address[3:2];
    assign sel_data    = (sel == REG_DATA);
    assign full        = (level_q == LEVEL_FULL);
    assign empty       = (level_q == '0);
    assign level       = level_q;
    assign level_ext   = 16'(level_q);
    assign unused_addr = ^{address[31:4], address[1:0]};

`ifdef AGENT_OVERFLOW_DROP_EN
    assign stall = read && !write && sel_data && empty;
`else
    assign stall = (write && sel_data && full) || (read && !write && sel_data && empty);
`endif
    assign waitrequest = !sys_rst && stall;

    // A simultaneous read+write is treated as the write alone.
    assign accept_wr = write && !stall;
    assign accept_rd = read && !write && !stall;
    assign push      = accept_wr && sel_data && !full;
    assign pop       = accept_rd && sel_data;
    assign clear     = accept_wr && (sel == REG_CTRL) && writedata[0];

    always_comb begin
        wr_word = '0;
        for (int b = 0; b < 4; b++) begin
            if (byteenable[b]) wr_word[8*b +: 8] = writedata[8*b +: 8];
        end
    end

`ifdef AGENT_OVERFLOW_DROP_EN
    logic [15:0] ovf_cnt;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ovf_cnt <= '0;
        end else if (accept_wr && (sel == REG_CTRL) && writedata[1]) begin
            ovf_cnt <= '0;
        end else if (accept_wr && sel_data && full && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (sel)
            REG_DATA:   rd_mux = mem[rd_ptr];
`ifdef AGENT_OVERFLOW_DROP_EN
            REG_STATUS: rd_mux = {ovf_cnt, level_ext};
            REG_CTRL:   rd_mux = {30'd0, full, empty};
`else
            REG_STATUS: rd_mux = {14'd0, full, empty, level_ext};
            REG_CTRL:   rd_mux = '0;
`endif
            REG_ID:     rd_mux = ID_VALUE;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (push) begin
            wr_ptr  <= wr_ptr + 1'b1;
            level_q <= level_q + 1'b1;
        end else if (pop) begin
            rd_ptr  <= rd_ptr + 1'b1;
            level_q <= level_q - 1'b1;
        end
    end

    // A response issued before a CTRL clear still completes because it is already registered here.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= accept_rd;
            if (accept_rd) readdata <= rd_mux;
        end
    end
endmodule
